fp32_adder_dual_align_stage: RTL and testbench
==============================================

Name: fp32_adder_dual_align_stage

Overview:
Front end of the dual-lane FP32 adder. It takes two independent operand pairs, one pair per lane. For each lane it unpacks the operands, selects the larger exponent, right-aligns the smaller mantissa, converts both to two's complement, and adds them. It produces exponent_big_N and the signed sum add_N, which feed fp32_adder_dual_normalization_stage directly. Pipelined: two cycles of latency, one result per clock.

Parameters:
EXPONENT_WIDTH, 8, biased exponent width
MANTISA_WIDTH, 24, mantissa width including hidden bit; add outputs are MANTISA_WIDTH+1 bits

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
valid_in  input  1  operand pairs on a/b inputs valid this cycle
a_0_in  input  32  lane 0 operand A, IEEE-754 single
b_0_in  input  32  lane 0 operand B
a_1_in  input  32  lane 1 operand A
b_1_in  input  32  lane 1 operand B
valid_out  output  1  exponent_big_N/add_N valid
exponent_big_0  output  EXPONENT_WIDTH  lane 0 larger biased exponent
exponent_big_1  output  EXPONENT_WIDTH  lane 1 larger biased exponent
add_0  output  MANTISA_WIDTH+1  lane 0 signed aligned sum, two's complement
add_1  output  MANTISA_WIDTH+1  lane 1 signed aligned sum

Behaviour:
- Reset: on posedge clk with rst=1, all pipeline registers clear. valid_out=0, exponent_big_N=0, add_N=0. rst has priority over valid_in.
- Latency: operands sampled at edge k appear on outputs after edge k+2. Fully pipelined, no stall or backpressure. valid_in=1 on consecutive cycles yields valid_out=1 on consecutive cycles.
- Data registers also update when valid is 0; only valid_out qualifies the outputs.
- Stage 1 (register), per lane:
  - Unpack sign, exp, and mant = {hidden, frac}. hidden = (exp != 0).
  - swap = (exp_b > exp_a). On a tie, A is "big".
  - Register exp_big, diff = exp_big - exp_small (unsigned 8-bit), mant_big, mant_small, sign_big, sign_small.
- Stage 2 (register), per lane:
  - shifted = (diff >= MANTISA_WIDTH) ? 0 : mant_small >> diff. Shifted-out bits are discarded; no guard, round or sticky bits.
  - Form 26-bit signed values: sv_big = sign_big ? -mant_big : +mant_big; sv_small likewise from shifted.
  - sum = sv_big + sv_small, 26-bit signed; cannot overflow.
  - add_N = sum[25:1], an arithmetic /2 dropping the LSB; exponent_big_N = exp_big. This matches the downstream +1 exponent correction.
- Zero result: add_N = 0 and exponent_big_N = exp_big; downstream treats it as zero.
- Special values: Inf/NaN are not decoded. Exponent 255 is processed as an ordinary exponent.
- Lanes are fully independent and share only clk, rst and valid.
- Reset mid-operation: in-flight data is discarded. valid_out is 0 from the edge after rst rises until two edges after the first valid_in following rst release.

Optional Feature:
Macro FP32_ALIGN_FTZ_EN.
- Defined: any operand with exp == 0 is flushed to +0 at unpack (mant = 0, sign = 0, exp treated as 0).
- Undefined: exp == 0 operands are denormals. hidden = 0, frac is kept, and the effective exponent is 1 for comparison and diff. exponent_big_N then reports 1 when both operands are denormal.

Test Plan:
1. Lane 0: a=0x3F800000, b=0x3F800000, valid_in=1 at edge 0 -> at edge 2: valid_out=1, exponent_big_0=127, add_0=0x0800000.
2. Lane 0: a=0x3F800000, b=0xBF800000 -> exponent_big_0=127, add_0=0.
3. Lane 1: a=0x40400000 (3.0), b=0xBFC00000 (-1.5) -> exponent_big_1=128, add_1=0x0300000. Swapped order gives the same result.
4. Lane 0: a=0x3F800000, b=0x30800000 (diff 30 >= 24) -> add_0=0x0400000, exponent_big_0=127. With diff 23 (b=0x34000000): add_0=0x0400000; the shifted-in 1 is lost to the /2 truncation.
5. Stream 4 back-to-back valid pairs, then assert rst for 1 cycle at edge 3 -> valid_out=0 and add_N=0 from edge 4. A new valid_in at edge 5 -> valid_out=1 at edge 7.
6. a=0x00400000, b=0x00400000 -> with FP32_ALIGN_FTZ_EN: add_0=0, exponent_big_0=0. Without: exponent_big_0=1, add_0=0x0400000.

Source files
------------

// File: rtl/fp32_adder_dual_align_stage.sv
// Dual-lane FP32 adder front end: unpack, pick larger exponent, align smaller mantissa, signed add (FP32_ALIGN_FTZ_EN flushes exp==0 operands to +0).
// Latency: 2 cycles, one result per clock.
// Backpressure: none; fully pipelined, data registers update every cycle and only valid_out qualifies them.

module fp32_adder_align_lane #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISA_WIDTH  = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               a,
  input  logic [31:0]               b,
  output logic [EXPONENT_WIDTH-1:0] exponent_big,
  output logic [MANTISA_WIDTH:0]    add
);
  localparam int EW = EXPONENT_WIDTH;
  localparam int MW = MANTISA_WIDTH;
  localparam logic [EW-1:0] EXP_ZERO   = '0;
  localparam logic [EW-1:0] EXP_ONE    = EW'(1);
  localparam logic [EW-1:0] DIFF_LIMIT = EW'(MW);

  typedef struct packed {
    logic [EW-1:0] exp_big;
    logic [EW-1:0] diff;
    logic [MW-1:0] mant_big;
    logic [MW-1:0] mant_small;
    logic          sign_big;
    logic          sign_small;
  } align_t;

  logic          sign_a;
  logic          sign_b;
  logic [EW-1:0] exp_a;
  logic [EW-1:0] exp_b;
  logic [MW-1:0] mant_a;
  logic [MW-1:0] mant_b;
  align_t        s1_d;
  align_t        s1_q;

  always_comb begin
    sign_a = a[EW+MW-1];
    sign_b = b[EW+MW-1];
    exp_a  = a[MW-1 +: EW];
    exp_b  = b[MW-1 +: EW];
    mant_a = {exp_a != EXP_ZERO, a[MW-2:0]};
    mant_b = {exp_b != EXP_ZERO, b[MW-2:0]};
`ifdef FP32_ALIGN_FTZ_EN
    if (exp_a == EXP_ZERO) begin
      sign_a = 1'b0;
      mant_a = '0;
    end
    if (exp_b == EXP_ZERO) begin
      sign_b = 1'b0;
      mant_b = '0;
    end
`else
    // Denormals share the exponent of the smallest normal.
    if (exp_a == EXP_ZERO) exp_a = EXP_ONE;
    if (exp_b == EXP_ZERO) exp_b = EXP_ONE;
`endif
    if (exp_b > exp_a) begin
      s1_d.exp_big    = exp_b;
      s1_d.diff       = exp_b - exp_a;
      s1_d.mant_big   = mant_b;
      s1_d.mant_small = mant_a;
      s1_d.sign_big   = sign_b;
      s1_d.sign_small = sign_a;
    end else begin
      s1_d.exp_big    = exp_a;
      s1_d.diff       = exp_a - exp_b;
      s1_d.mant_big   = mant_a;
      s1_d.mant_small = mant_b;
      s1_d.sign_big   = sign_a;
      s1_d.sign_small = sign_b;
    end
  end

  logic [MW-1:0] shifted;
  logic [MW+1:0] sv_big;
  logic [MW+1:0] sv_small;
  logic [MW+1:0] sum;
  logic [MW:0]   add_d;

  always_comb begin
    shifted  = (s1_q.diff >= DIFF_LIMIT) ? '0 : (s1_q.mant_small >> s1_q.diff);
    sv_big   = {2'b00, s1_q.mant_big};
    sv_small = {2'b00, shifted};
    if (s1_q.sign_big)   sv_big   = -sv_big;
    if (s1_q.sign_small) sv_small = -sv_small;
    sum   = sv_big + sv_small;
    // Halve so the sum fits MW+1 bits; downstream adds 1 to the exponent.
    add_d = (MW+1)'($signed(sum) >>> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= '0;
      exponent_big <= '0;
      add          <= '0;
    end else begin
      s1_q         <= s1_d;
      exponent_big <= s1_q.exp_big;
      add          <= add_d;
    end
  end
endmodule

module fp32_adder_dual_align_stage #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISA_WIDTH  = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic [31:0]               a_0_in,
  input  logic [31:0]               b_0_in,
  input  logic [31:0]               a_1_in,
  input  logic [31:0]               b_1_in,
  output logic                      valid_out,
  output logic [EXPONENT_WIDTH-1:0] exponent_big_0,
  output logic [EXPONENT_WIDTH-1:0] exponent_big_1,
  output logic [MANTISA_WIDTH:0]    add_0,
  output logic [MANTISA_WIDTH:0]    add_1
);
  logic valid_s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_s1  <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_s1  <= valid_in;
      valid_out <= valid_s1;
    end
  end

  fp32_adder_align_lane #(
    .EXPONENT_WIDTH(EXPONENT_WIDTH),
    .MANTISA_WIDTH (MANTISA_WIDTH)
  ) u_lane_0 (
    .clk         (clk),
    .rst         (rst),
    .a           (a_0_in),
    .b           (b_0_in),
    .exponent_big(exponent_big_0),
    .add         (add_0)
  );

  fp32_adder_align_lane #(
    .EXPONENT_WIDTH(EXPONENT_WIDTH),
    .MANTISA_WIDTH (MANTISA_WIDTH)
  ) u_lane_1 (
    .clk         (clk),
    .rst         (rst),
    .a           (a_1_in),
    .b           (b_1_in),
    .exponent_big(exponent_big_1),
    .add         (add_1)
  );
endmodule

// File: tb/tb_fp32_adder_dual_align_stage.sv
// Bench for fp32_adder_dual_align_stage: directed cases plus randomized traffic
// checked every cycle against an arithmetic reference of the alignment/add.
module tb_fp32_adder_dual_align_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] a_0_in = '0;
  logic [31:0] b_0_in = '0;
  logic [31:0] a_1_in = '0;
  logic [31:0] b_1_in = '0;
  logic        valid_out;
  logic [7:0]  exponent_big_0;
  logic [7:0]  exponent_big_1;
  logic [24:0] add_0;
  logic [24:0] add_1;

  always #5 clk = ~clk;

  fp32_adder_dual_align_stage dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .a_0_in        (a_0_in),
    .b_0_in        (b_0_in),
    .a_1_in        (a_1_in),
    .b_1_in        (b_1_in),
    .valid_out     (valid_out),
    .exponent_big_0(exponent_big_0),
    .exponent_big_1(exponent_big_1),
    .add_0         (add_0),
    .add_1         (add_1)
  );

  typedef struct {
    logic        vld;
    logic [7:0]  e0;
    logic [24:0] a0;
    logic [7:0]  e1;
    logic [24:0] a1;
  } res_t;

  res_t s1 = '{default: '0};
  res_t s2 = '{default: '0};
  int   passes = 0;
  int   total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) passes++;
    else $error("FAIL %s observed=0x%0h required=0x%0h", tag, obs, req);
  endtask

  function automatic void decode(input logic [31:0] x, output int s, output int e, output int m);
    s = int'(x[31]);
    e = int'(x[30:23]);
    m = int'(x[22:0]);
`ifdef FP32_ALIGN_FTZ_EN
    if (e == 0) begin
      s = 0;
      m = 0;
    end else m += (1 << 23);
`else
    if (e == 0) e = 1;
    else m += (1 << 23);
`endif
  endfunction

  function automatic void lane_ref(input logic [31:0] a, input logic [31:0] b,
                                   output logic [7:0] eb, output logic [24:0] half);
    int sa, ea, ma, sb, ebb, mb;
    int s_big, e_big, m_big, s_sm, e_sm, m_sm, sh, sum_v;
    decode(a, sa, ea, ma);
    decode(b, sb, ebb, mb);
    if (ebb > ea) begin
      s_big = sb; e_big = ebb; m_big = mb; s_sm = sa; e_sm = ea; m_sm = ma;
    end else begin
      s_big = sa; e_big = ea; m_big = ma; s_sm = sb; e_sm = ebb; m_sm = mb;
    end
    sh    = (e_big - e_sm >= 24) ? 0 : (m_sm >> (e_big - e_sm));
    sum_v = (s_big != 0 ? -m_big : m_big) + (s_sm != 0 ? -sh : sh);
    eb    = 8'(e_big);
    half  = 25'(sum_v >>> 1);
  endfunction

  function automatic logic [31:0] rand_fp(input logic [7:0] base);
    logic [7:0] e;
    case ($urandom_range(0, 3))
      0:       e = 8'($urandom_range(0, 255));
      1:       e = base + 8'($urandom_range(0, 30));
      2:       e = 8'h00;
      default: e = base;
    endcase
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // One clock: update the reference from sampled inputs, then compare all outputs.
  task automatic step();
    res_t nxt;
    @(posedge clk);
    nxt.vld = valid_in;
    lane_ref(a_0_in, b_0_in, nxt.e0, nxt.a0);
    lane_ref(a_1_in, b_1_in, nxt.e1, nxt.a1);
    s2 = rst ? '{default: '0} : s1;
    s1 = rst ? '{default: '0} : nxt;
    #1;
    check("valid_out", 32'(valid_out), 32'(s2.vld));
    check("exp_big_0", 32'(exponent_big_0), 32'(s2.e0));
    check("add_0", 32'(add_0), 32'(s2.a0));
    check("exp_big_1", 32'(exponent_big_1), 32'(s2.e1));
    check("add_1", 32'(add_1), 32'(s2.a1));
  endtask

  task automatic drive_rand(input logic v);
    logic [7:0] base;
    base     = 8'($urandom_range(1, 220));
    valid_in = v;
    a_0_in   = rand_fp(base);
    b_0_in   = rand_fp(base);
    a_1_in   = rand_fp(base);
    b_1_in   = rand_fp(base);
  endtask

  task automatic apply_pair(input logic [31:0] a0, input logic [31:0] b0,
                            input logic [31:0] a1, input logic [31:0] b1);
    a_0_in = a0; b_0_in = b0; a_1_in = a1; b_1_in = b1;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    step();
  endtask

  initial begin
    step();
    step();
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_add_0", 32'(add_0), 32'd0);
    check("rst_exp_big_1", 32'(exponent_big_1), 32'd0);
    rst = 1'b0;
    step();

    // 1.0 + 1.0 on lane 0, 3.0 + -1.5 on lane 1
    apply_pair(32'h3F800000, 32'h3F800000, 32'h40400000, 32'hBFC00000);
    check("t1_valid", 32'(valid_out), 32'd1);
    check("t1_exp0", 32'(exponent_big_0), 32'd127);
    check("t1_add0", 32'(add_0), 32'h0800000);
    check("t3_exp1", 32'(exponent_big_1), 32'd128);
    check("t3_add1", 32'(add_1), 32'h0300000);

    // cancellation on lane 0, swapped operand order on lane 1
    apply_pair(32'h3F800000, 32'hBF800000, 32'hBFC00000, 32'h40400000);
    check("t2_exp0", 32'(exponent_big_0), 32'd127);
    check("t2_add0", 32'(add_0), 32'd0);
    check("t3s_exp1", 32'(exponent_big_1), 32'd128);
    check("t3s_add1", 32'(add_1), 32'h0300000);

    // diff 30 on lane 0, diff 23 on lane 1
    apply_pair(32'h3F800000, 32'h30800000, 32'h3F800000, 32'h34000000);
    check("t4_add0", 32'(add_0), 32'h0400000);
    check("t4_exp0", 32'(exponent_big_0), 32'd127);
    check("t4_add1_d23", 32'(add_1), 32'h0400000);

    // two denormals
    apply_pair(32'h00400000, 32'h00400000, 32'h00400000, 32'h00400000);
`ifdef FP32_ALIGN_FTZ_EN
    check("t6_exp0", 32'(exponent_big_0), 32'd0);
    check("t6_add0", 32'(add_0), 32'd0);
`else
    check("t6_exp0", 32'(exponent_big_0), 32'd1);
    check("t6_add0", 32'(add_0), 32'h0400000);
`endif

    // back-to-back stream, then reset mid-flight
    for (int i = 0; i < 4; i++) begin
      drive_rand(1'b1);
      step();
      if (i >= 1) check("stream_valid", 32'(valid_out), 32'd1);
    end
    drive_rand(1'b1);
    rst = 1'b1;
    step();
    check("rst_mid_valid", 32'(valid_out), 32'd0);
    check("rst_mid_add0", 32'(add_0), 32'd0);
    check("rst_mid_add1", 32'(add_1), 32'd0);
    rst = 1'b0;
    valid_in = 1'b0;
    step();
    check("post_rst_valid", 32'(valid_out), 32'd0);
    drive_rand(1'b1);
    step();
    check("post_rst_lat1", 32'(valid_out), 32'd0);
    valid_in = 1'b0;
    step();
    check("post_rst_lat2", 32'(valid_out), 32'd1);

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      drive_rand(1'($urandom_range(0, 1)));
      rst = ($urandom_range(0, 39) == 0);
      step();
    end
    rst = 1'b0;
    valid_in = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
